// File: rtl/lfsr_arbiter.sv
// Round-robin sharing of one external LFSR among NUM_REQ requesters.
// Sequences seed loads, one advance per grant, and recovery from the all-zero state.
module lfsr_arbiter #(
    parameter int                    LFSR_WIDTH = 13,
    parameter int                    NUM_REQ    = 4,
    parameter logic [LFSR_WIDTH-1:0] DEF_SEED   = LFSR_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  rnd_valid,
    output logic [LFSR_WIDTH-1:0] rnd_data,
    input  logic                  seed_wr,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    output logic                  lfsr_load,
    output logic [LFSR_WIDTH-1:0] lfsr_seed,
    output logic                  lfsr_step,
    input  logic [LFSR_WIDTH-1:0] lfsr_q,
    output logic                  lockup
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STEP, CAPTURE} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr, winner, pick;
    logic                  seed_pend;
    logic [LFSR_WIDTH-1:0] seed_reg;

    // Descending scan so the last hit is the first set bit at or above rr_ptr.
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_REQ])
                pick = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (seed_pend)     state_nxt = LOAD;
                else if (|req)     state_nxt = STEP;
            end
            LOAD:    state_nxt = IDLE;
            STEP:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign lfsr_load = (state == LOAD);
    assign lfsr_step = (state == STEP);
    assign lfsr_seed = (state == LOAD) ? seed_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            winner    <= '0;
            seed_pend <= 1'b0;
            seed_reg  <= DEF_SEED;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            lockup    <= 1'b0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            case (state)
                IDLE: if (!seed_pend && |req) winner <= pick;
                LOAD: seed_pend <= 1'b0;
                CAPTURE: begin
                    if (lfsr_q != '0) begin
                        rnd_data  <= lfsr_q;
                        gnt       <= NUM_REQ'(1) << winner;
                        rnd_valid <= 1'b1;
                        rr_ptr    <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    end else begin
                        // Held request stays pending and is re-arbitrated after the reload.
                        lockup    <= 1'b1;
                        seed_reg  <= DEF_SEED;
                        seed_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
            // A fresh seed write overrides both the LOAD clear and the lockup reseed.
            if (seed_wr) begin
                seed_pend <= 1'b1;
                seed_reg  <= (seed_in == '0) ? DEF_SEED : seed_in;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter with a behavioural LFSR and a round-robin/word-sequence model.
module tb_lfsr_arbiter;
    localparam int           LW  = 13;
    localparam int           N   = 4;
    localparam logic [LW-1:0] DEF  = 13'h0001;
    localparam logic [LW-1:0] RSTQ = 13'h0ACE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic          rnd_valid;
    logic [LW-1:0] rnd_data;
    logic          seed_wr = 1'b0;
    logic [LW-1:0] seed_in = '0;
    logic          lfsr_load;
    logic [LW-1:0] lfsr_seed;
    logic          lfsr_step;
    logic [LW-1:0] lfsr_q;
    logic          lockup;
    logic [LW-1:0] model_q;
    logic          force0 = 1'b0;
    logic [2:0][N-1:0] req_h;

    int            total = 0;
    int            bad = 0;
    int            ptr = 0;
    logic [LW-1:0] ref_q = RSTQ;

    lfsr_arbiter #(.LFSR_WIDTH(LW), .NUM_REQ(N), .DEF_SEED(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .seed_wr(seed_wr), .seed_in(seed_in),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
        .lfsr_q(lfsr_q), .lockup(lockup)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] q);
        return {q[LW-2:0], q[12] ^ q[3] ^ q[2] ^ q[0]};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int e);
        logic [N-1:0] v = '0;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    // External LFSR the arbiter drives
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         model_q <= RSTQ;
        else if (lfsr_load) model_q <= lfsr_seed;
        else if (lfsr_step) model_q <= lfsr_next(model_q);
    end
    assign lfsr_q = force0 ? '0 : model_q;

    always @(posedge clk) req_h <= {req_h[1:0], req};

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (lfsr_load && lfsr_step) begin
                bad++; $display("FAIL strobe_overlap load=%b step=%b required not both", lfsr_load, lfsr_step);
            end
            total++;
            if (rnd_valid !== (|gnt) || $countones(gnt) > 1) begin
                bad++; $display("FAIL valid_gnt rnd_valid=%b gnt=%b required onehot and coincident", rnd_valid, gnt);
            end
        end
    end

    task automatic wait_gnt(output logic [N-1:0] g, output logic [LW-1:0] d, output int cyc);
        g = '0; d = '0; cyc = 0;
        while (g == '0 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (gnt != '0) begin g = gnt; d = rnd_data; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt, rnd_valid, rnd_data, lfsr_load, lfsr_step, lfsr_seed, lockup} !== '0) begin
            bad++; $display("FAIL reset_outputs gnt=%b v=%b d=%h ld=%b st=%b seed=%h lk=%b required all 0",
                            gnt, rnd_valid, rnd_data, lfsr_load, lfsr_step, lfsr_seed, lockup);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (lfsr_load || lfsr_step || gnt != '0) begin
            bad++; $display("FAIL reset_idle ld=%b st=%b gnt=%b required idle", lfsr_load, lfsr_step, gnt);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] g; logic [LW-1:0] d; int c, e;
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (lfsr_step !== 1'b1) begin bad++; $display("FAIL single_step got=%b required 1", lfsr_step); end
        wait_gnt(g, d, c);
        e = rr_pick(4'b0001, ptr);
        ref_q = lfsr_next(ref_q);
        total++;
        if (g !== onehot(e) || c != 2) begin
            bad++; $display("FAIL single_gnt got=%b after %0d required %b after 2", g, c, onehot(e));
        end
        total++;
        if (d !== ref_q) begin bad++; $display("FAIL single_data got=%h required %h", d, ref_q); end
        req = '0; ptr = (e + 1) % N;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g; logic [LW-1:0] d; int c, e;
        logic [LW-1:0] words[5];
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, d, c);
            e = rr_pick(4'b1111, ptr);
            ref_q = lfsr_next(ref_q);
            words[k] = d;
            total++;
            if (g !== onehot(e) || c != 3) begin
                bad++; $display("FAIL rr_gnt[%0d] got=%b after %0d required %b after 3", k, g, c, onehot(e));
            end
            total++;
            if (d !== ref_q) begin bad++; $display("FAIL rr_data[%0d] got=%h required %h", k, d, ref_q); end
            ptr = (e + 1) % N;
        end
        req = '0;
        for (int a = 0; a < 5; a++)
            for (int b = a + 1; b < 5; b++) begin
                total++;
                if (words[a] === words[b]) begin
                    bad++; $display("FAIL rr_distinct word%0d=%h word%0d=%h required distinct", a, words[a], b, words[b]);
                end
            end
        @(negedge clk);
    endtask

    task automatic test_seed();
        logic [N-1:0] g; logic [LW-1:0] d; int c, e;
        bit step_first = 0, got_load = 0;
        seed_in = 13'h1ABC; seed_wr = 1'b1;
        @(negedge clk);
        seed_wr = 1'b0; req = 4'b0010;
        for (int k = 0; k < 10 && !got_load; k++) begin
            @(negedge clk);
            if (lfsr_step) step_first = 1;
            if (lfsr_load) got_load = 1;
        end
        total++;
        if (!got_load || step_first || lfsr_seed !== 13'h1ABC) begin
            bad++; $display("FAIL seed_load loaded=%0d step_first=%0d seed=%h required 1 0 1abc",
                            got_load, step_first, lfsr_seed);
        end
        ref_q = 13'h1ABC;
        wait_gnt(g, d, c);
        e = rr_pick(4'b0010, ptr);
        ref_q = lfsr_next(ref_q);
        total++;
        if (g !== onehot(e) || d !== ref_q) begin
            bad++; $display("FAIL seed_grant got=%b/%h required %b/%h", g, d, onehot(e), ref_q);
        end
        req = '0; ptr = (e + 1) % N;
    endtask

    task automatic test_seed_zero();
        logic [N-1:0] g; logic [LW-1:0] d; int c, e;
        bit got_load = 0;
        seed_in = '0; seed_wr = 1'b1;
        @(negedge clk);
        seed_wr = 1'b0;
        for (int k = 0; k < 6 && !got_load; k++) begin
            @(negedge clk);
            if (lfsr_load) got_load = 1;
        end
        total++;
        if (!got_load || lfsr_seed !== DEF) begin
            bad++; $display("FAIL seed_zero loaded=%0d seed=%h required 1 %h", got_load, lfsr_seed, DEF);
        end
        // A write landing in the LOAD cycle must trigger a second load with the new value
        seed_in = 13'h0777; seed_wr = 1'b1;
        @(negedge clk);
        seed_wr = 1'b0;
        got_load = 0;
        for (int k = 0; k < 5 && !got_load; k++) begin
            if (lfsr_load) got_load = 1;
            else @(negedge clk);
        end
        total++;
        if (!got_load || lfsr_seed !== 13'h0777) begin
            bad++; $display("FAIL seed_in_load loaded=%0d seed=%h required 1 0777", got_load, lfsr_seed);
        end
        ref_q = 13'h0777;
        @(negedge clk);
        req = 4'b1000;
        wait_gnt(g, d, c);
        e = rr_pick(4'b1000, ptr);
        ref_q = lfsr_next(ref_q);
        total++;
        if (g !== onehot(e) || d !== ref_q) begin
            bad++; $display("FAIL seed_zero_grant got=%b/%h required %b/%h", g, d, onehot(e), ref_q);
        end
        req = '0; ptr = (e + 1) % N;
    endtask

    task automatic test_lockup();
        logic [N-1:0] g; logic [LW-1:0] d; int c, e;
        bit got_load = 0;
        force0 = 1'b1; req = 4'b0100;
        for (int k = 0; k < 10 && !lockup; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== '0) begin bad++; $display("FAIL lockup_nogrant got=%b required 0000", gnt); end
        end
        total++;
        if (lockup !== 1'b1) begin bad++; $display("FAIL lockup_set got=%b required 1", lockup); end
        force0 = 1'b0;
        for (int k = 0; k < 6 && !got_load; k++) begin
            @(negedge clk);
            if (lfsr_load) got_load = 1;
        end
        total++;
        if (!got_load || lfsr_seed !== DEF) begin
            bad++; $display("FAIL lockup_reload loaded=%0d seed=%h required 1 %h", got_load, lfsr_seed, DEF);
        end
        ref_q = DEF;
        wait_gnt(g, d, c);
        e = rr_pick(4'b0100, ptr);
        ref_q = lfsr_next(ref_q);
        total++;
        if (g !== onehot(e) || d !== ref_q || lockup !== 1'b1) begin
            bad++; $display("FAIL lockup_grant got=%b/%h lk=%b required %b/%h lk=1", g, d, lockup, onehot(e), ref_q);
        end
        req = '0; ptr = (e + 1) % N;
    endtask

    task automatic test_random();
        int e, ngr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (gnt != '0) begin
                e = rr_pick(req_h[2], ptr);
                ref_q = lfsr_next(ref_q);
                total++;
                if (gnt !== onehot(e)) begin
                    bad++; $display("FAIL rand_gnt cyc=%0d got=%b required %b", cyc, gnt, onehot(e));
                end
                total++;
                if (rnd_data !== ref_q) begin
                    bad++; $display("FAIL rand_data cyc=%0d got=%h required %h", cyc, rnd_data, ref_q);
                end
                if (e >= 0) ptr = (e + 1) % N;
                req = req & ~gnt;
                ngr++;
            end
            if (cyc < 340)
                for (int i = 0; i < N; i++)
                    if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
        total++;
        if (req !== '0 || ngr < 20) begin
            bad++; $display("FAIL rand_drain pending=%b grants=%0d required 0000 and >=20", req, ngr);
        end
    endtask

    task automatic test_reset_mid_step();
        logic [N-1:0] g; logic [LW-1:0] d; int c, e;
        req = 4'b0100;
        for (int k = 0; k < 5 && !lfsr_step; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, rnd_valid, rnd_data, lfsr_load, lfsr_step, lfsr_seed, lockup} !== '0) begin
            bad++; $display("FAIL midstep_reset gnt=%b v=%b d=%h ld=%b st=%b seed=%h lk=%b required all 0",
                            gnt, rnd_valid, rnd_data, lfsr_load, lfsr_step, lfsr_seed, lockup);
        end
        req = '0; ptr = 0; ref_q = RSTQ;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001;
        wait_gnt(g, d, c);
        e = rr_pick(4'b1001, ptr);
        ref_q = lfsr_next(ref_q);
        total++;
        if (g !== onehot(e) || d !== ref_q) begin
            bad++; $display("FAIL post_reset_first got=%b/%h required %b/%h", g, d, onehot(e), ref_q);
        end
        req[e] = 1'b0; ptr = (e + 1) % N;
        wait_gnt(g, d, c);
        e = rr_pick(4'b1000, ptr);
        ref_q = lfsr_next(ref_q);
        total++;
        if (g !== onehot(e) || d !== ref_q || c != 3) begin
            bad++; $display("FAIL post_reset_second got=%b/%h after %0d required %b/%h after 3",
                            g, d, c, onehot(e), ref_q);
        end
        req = '0; ptr = (e + 1) % N;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_seed();
        test_seed_zero();
        test_lockup();
        test_random();
        test_reset_mid_step();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
